// File: rtl/rf_wb_sched_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_sched_pkg : shared widths and helpers for the writeback scheduler
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none
`include "xgriscv_defines.v"

package rf_wb_sched_pkg;

    localparam int XLEN_W  = `XLEN;
    localparam int RFIDX_W = `RFIDX_WIDTH;
    localparam int RFREG_N = `RFREG_NUM;

    // Modulo-n increment for indices that are already in 0..n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wb_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, scanning upward from ptr
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import rf_wb_sched_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = int'(ptr);
        for (int k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
            idx = wrap_inc(idx, N);
        end
    end

endmodule

`default_nettype wire

// File: rtl/xgriscv_defines.v
// Global xgriscv core widths shared by every core block.
`ifndef XGRISCV_DEFINES_V
`define XGRISCV_DEFINES_V
`define XLEN        32
`define RFIDX_WIDTH 5
`define RFREG_NUM   32
`endif

// File: rtl/rf_wb_sched.sv
// ---------------------------------------------------------------------------
// rf_wb_sched : round-robin regfile write-port sharing plus busy scoreboard
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int XLEN  = XLEN_W,
    parameter int RFIDX = RFIDX_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*RFIDX-1:0] req_addr,
    input  logic [NREQ*XLEN-1:0]  req_data,
    output logic                  rf_we,
    output logic [RFIDX-1:0]      rf_wa,
    output logic [XLEN-1:0]       rf_wd,
    input  logic                  sb_set,
    input  logic [RFIDX-1:0]      sb_set_addr,
    input  logic                  flush,
    input  logic [RFIDX-1:0]      chk_rs1,
    input  logic [RFIDX-1:0]      chk_rs2,
    input  logic [RFIDX-1:0]      chk_rd,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy
);

    localparam int PW    = $clog2(NREQ);
    localparam int NREGS = 2 ** RFIDX;

    logic [PW-1:0]    ptr_q,  ptr_d;
    logic [NREGS-1:0] busy_q, busy_d;

    logic [NREQ-1:0]  w_gnt;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_grant;
    logic [RFIDX-1:0] w_gnt_addr;
    logic [XLEN-1:0]  w_gnt_data;
    logic             w_sb_dup_set;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Requests seen during reset are dropped, so the grant is masked here too.
    always_comb begin
        w_grant    = (|w_gnt) & ~reset;
        w_gnt_addr = req_addr[w_gnt_idx*RFIDX +: RFIDX];
        w_gnt_data = req_data[w_gnt_idx*XLEN +: XLEN];
        req_ready  = reset ? '0 : w_gnt;
        rf_we      = w_grant & (w_gnt_addr != '0);
        rf_wa      = w_grant ? w_gnt_addr : '0;
        rf_wd      = w_grant ? w_gnt_data : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_grant) begin
            ptr_d = PW'(wrap_inc(int'(w_gnt_idx), NREQ));
        end
    end

    // Set wins over a same-cycle retire: the reservation is the younger one.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        if (w_grant) begin
            busy_d[w_gnt_addr] = 1'b0;
        end
        if (sb_set) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs1_busy = busy_q[chk_rs1];
        rs2_busy = busy_q[chk_rs2];
        rd_busy  = busy_q[chk_rd];
    end

    always_comb begin
        w_sb_dup_set = sb_set && (sb_set_addr != '0) && busy_q[sb_set_addr]
                       && !flush && !(w_grant && (w_gnt_addr == sb_set_addr));
    end

    a_no_dup_reserve: assert property (@(posedge clk) disable iff (reset)
        !w_sb_dup_set);

    for (genvar i = 0; i < NREQ; i++) begin : g_req_proto
        a_req_hold: assert property (@(posedge clk) disable iff (reset)
            (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(req_addr[i*RFIDX +: RFIDX])
                          && $stable(req_data[i*XLEN +: XLEN])));
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_sched : directed vectors for rf_wb_sched with hand-computed results
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rf_wb_sched;

    localparam int NREQ  = 3;
    localparam int XLEN  = 32;
    localparam int RFIDX = 5;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*RFIDX-1:0] req_addr = '0;
    logic [NREQ*XLEN-1:0]  req_data = '0;
    logic                  rf_we;
    logic [RFIDX-1:0]      rf_wa;
    logic [XLEN-1:0]       rf_wd;
    logic                  sb_set = 1'b0;
    logic [RFIDX-1:0]      sb_set_addr = '0;
    logic                  flush = 1'b0;
    logic [RFIDX-1:0]      chk_rs1 = '0;
    logic [RFIDX-1:0]      chk_rs2 = '0;
    logic [RFIDX-1:0]      chk_rd = '0;
    logic                  rs1_busy, rs2_busy, rd_busy;

    int n_vec = 0;
    int n_bad = 0;

    rf_wb_sched #(.NREQ(NREQ), .XLEN(XLEN), .RFIDX(RFIDX)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .flush       (flush),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rd      (chk_rd),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_busy     (rd_busy)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled 3 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_req(input int i, input logic [RFIDX-1:0] a, input logic [XLEN-1:0] d);
        req_addr[i*RFIDX +: RFIDX] = a;
        req_data[i*XLEN +: XLEN]   = d;
    endtask

    task automatic pulse_reset();
        tick();
        reset     = 1'b1;
        req_valid = '0;
        sb_set    = 1'b0;
        flush     = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset held with all requesters valid.
        set_req(0, 5'd1, 32'h1111_0001);
        set_req(1, 5'd2, 32'h2222_0002);
        set_req(2, 5'd3, 32'h3333_0003);
        req_valid = 3'b111;
        chk_rs1 = 5'd1; chk_rs2 = 5'd2; chk_rd = 5'd3;
        tick(); settle();
        check_vec("rst_ready", 32'(req_ready), 32'h0);
        check_vec("rst_we",    32'(rf_we),     32'h0);
        check_vec("rst_wa",    32'(rf_wa),     32'h0);
        check_vec("rst_busy",  32'({rs1_busy, rs2_busy, rd_busy}), 32'h0);

        // Release: grants rotate 0,1,2,0.
        tick(); reset = 1'b0; settle();
        check_vec("rr0_ready", 32'(req_ready), 32'h1);
        check_vec("rr0_wa",    32'(rf_wa),     32'h1);
        check_vec("rr0_wd",    rf_wd,          32'h1111_0001);
        tick(); settle();
        check_vec("rr1_ready", 32'(req_ready), 32'h2);
        check_vec("rr1_wd",    rf_wd,          32'h2222_0002);
        tick(); settle();
        check_vec("rr2_ready", 32'(req_ready), 32'h4);
        check_vec("rr2_wa",    32'(rf_wa),     32'h3);
        tick(); settle();
        check_vec("rr3_ready", 32'(req_ready), 32'h1);

        // Single writer to x5 that was reserved one cycle earlier.
        pulse_reset();
        sb_set = 1'b1; sb_set_addr = 5'd5; chk_rs1 = 5'd5;
        settle();
        check_vec("set_lat0", 32'(rs1_busy), 32'h0);
        tick();
        sb_set = 1'b0;
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        settle();
        check_vec("sw_ready", 32'(req_ready), 32'h2);
        check_vec("sw_we",    32'(rf_we),     32'h1);
        check_vec("sw_wa",    32'(rf_wa),     32'h5);
        check_vec("sw_wd",    rf_wd,          32'hDEAD_BEEF);
        check_vec("sw_busy",  32'(rs1_busy),  32'h1);
        tick();
        req_valid = '0;
        settle();
        check_vec("sw_clr",    32'(rs1_busy),  32'h0);
        check_vec("idle_ready",32'(req_ready), 32'h0);
        check_vec("idle_we",   32'(rf_we),     32'h0);
        check_vec("idle_wd",   rf_wd,          32'h0);

        // Fairness with requesters 0 and 2 always valid.
        pulse_reset();
        set_req(0, 5'd10, 32'hAAAA_000A);
        set_req(2, 5'd11, 32'hBBBB_000B);
        req_valid = 3'b101;
        settle();
        check_vec("fair0", 32'(req_ready), 32'h1);
        tick(); settle();
        check_vec("fair1", 32'(req_ready), 32'h4);
        check_vec("fair1_wa", 32'(rf_wa), 32'd11);
        tick(); settle();
        check_vec("fair2", 32'(req_ready), 32'h1);
        tick(); settle();
        check_vec("fair3", 32'(req_ready), 32'h4);
        tick();
        req_valid = 3'b001;
        settle();
        check_vec("fair4", 32'(req_ready), 32'h1);

        // Write to x0 from requester 2 (ptr now 1) plus reservation of x0.
        tick();
        set_req(2, 5'd0, 32'h0000_0001);
        req_valid = 3'b100;
        sb_set = 1'b1; sb_set_addr = 5'd0;
        settle();
        check_vec("x0_ready", 32'(req_ready), 32'h4);
        check_vec("x0_we",    32'(rf_we),     32'h0);
        check_vec("x0_wd",    rf_wd,          32'h1);
        tick();
        req_valid = '0; sb_set = 1'b0; chk_rs1 = 5'd0;
        settle();
        check_vec("x0_busy",  32'(rs1_busy),  32'h0);
        check_vec("x0_gone",  32'(req_ready), 32'h0);

        // Same-cycle retire and reserve of x7 (ptr now 0).
        sb_set = 1'b1; sb_set_addr = 5'd7; chk_rd = 5'd7;
        tick();
        set_req(0, 5'd7, 32'h7777_0007);
        req_valid = 3'b001;
        settle();
        check_vec("col_ready", 32'(req_ready), 32'h1);
        check_vec("col_pre",   32'(rd_busy),   32'h1);
        tick();
        req_valid = '0; sb_set = 1'b1; sb_set_addr = 5'd8;
        settle();
        check_vec("col_busy7", 32'(rd_busy), 32'h1);

        // Same collision with flush; x8 reserved the cycle before (ptr now 1).
        tick();
        chk_rs2 = 5'd8; chk_rs1 = 5'd9;
        sb_set_addr = 5'd7; flush = 1'b1; req_valid = 3'b001;
        settle();
        check_vec("fl_pre8",  32'(rs2_busy),  32'h1);
        check_vec("fl_ready", 32'(req_ready), 32'h1);
        check_vec("fl_we",    32'(rf_we),     32'h1);
        tick();
        flush = 1'b0; req_valid = '0; sb_set = 1'b0;
        settle();
        check_vec("fl_busy7", 32'(rd_busy),  32'h1);
        check_vec("fl_busy8", 32'(rs2_busy), 32'h0);
        check_vec("fl_busy9", 32'(rs1_busy), 32'h0);

        // Build busy = 0xF0, then reset asynchronously during a grant to 1.
        sb_set = 1'b1; sb_set_addr = 5'd4;
        tick(); sb_set_addr = 5'd5;
        tick(); sb_set_addr = 5'd6;
        tick();
        sb_set = 1'b0; chk_rs1 = 5'd4; chk_rs2 = 5'd6; chk_rd = 5'd7;
        set_req(1, 5'd9, 32'h0000_0123);
        req_valid = 3'b010;
        #1;
        check_vec("mid_ready", 32'(req_ready), 32'h2);
        check_vec("mid_we",    32'(rf_we),     32'h1);
        check_vec("mid_busy",  32'({rs1_busy, rs2_busy, rd_busy}), 32'h7);
        #1 reset = 1'b1;
        #1;
        check_vec("async_we",    32'(rf_we),     32'h0);
        check_vec("async_ready", 32'(req_ready), 32'h0);
        check_vec("async_busy",  32'({rs1_busy, rs2_busy, rd_busy}), 32'h0);
        tick();
        reset = 1'b0;
        req_valid = 3'b111;
        settle();
        check_vec("post_ptr0", 32'(req_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
